// File: rtl/game_pkg.sv
// Shared definitions for the reaction game: controller states, LED constants
// and the index-to-one-hot helper also used by the LED driver.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LED_ALL_ON = 4'b1111;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    idx_to_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that parks at zero; load wins over the countdown.
module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/target_round_ctrl.sv
// Round controller: lights one of four targets per round, scores the player's
// press or timeout, and keeps saturating hit/miss counts over a game.
module target_round_ctrl
  import game_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int ON_CYCLES  = 6,
  parameter int NUM_ROUNDS = 16,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         random_num,
  input  logic [3:0]         btn,
  output logic [3:0]         led,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] hits,
  output logic [SCORE_W-1:0] misses,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  localparam int MAX_CYC = (GAP_CYCLES > ON_CYCLES) ? GAP_CYCLES : ON_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int RW      = $clog2(NUM_ROUNDS + 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] ON_LOAD    = TW'(ON_CYCLES - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

  state_t             r_state;
  logic [1:0]         r_target;
  logic [RW-1:0]      r_round;
  logic [SCORE_W-1:0] r_hits;
  logic [SCORE_W-1:0] r_misses;
  logic               r_hit;
  logic               r_miss;

  logic          w_zero;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic [3:0]    w_tgt_oh;
  logic          w_in_show;
  logic          w_press_hit;
  logic          w_press_miss;
  logic          w_timeout;
  logic          w_scored;
  logic          w_last_round;
  logic          w_start_ok;

  assign w_tgt_oh     = idx_to_onehot(r_target);
  assign w_in_show    = (r_state == SHOW);
  // A press in the timeout cycle is scored as a press, never as a timeout.
  assign w_press_hit  = w_in_show && (btn == w_tgt_oh);
  assign w_press_miss = w_in_show && (btn != 4'b0000) && (btn != w_tgt_oh);
  assign w_timeout    = w_in_show && (btn == 4'b0000) && w_zero;
  assign w_scored     = w_press_hit || w_press_miss || w_timeout;
  assign w_last_round = (r_round == LAST_ROUND);
  assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE));

  always_comb begin
    w_load     = 1'b0;
    w_load_val = GAP_LOAD;
    if (w_start_ok) begin
      w_load = 1'b1;
    end else if ((r_state == GAP) && w_zero) begin
      w_load     = 1'b1;
      w_load_val = ON_LOAD;
    end else if (w_scored && !w_last_round) begin
      w_load = 1'b1;
    end
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .value (w_load_val),
    .zero  (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_target <= 2'd0;
      r_round  <= '0;
      r_hits   <= '0;
      r_misses <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= GAP;
            r_round  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
          end
        end
        GAP: begin
          if (w_zero) begin
            r_state  <= SHOW;
            r_target <= random_num;
          end
        end
        SHOW: begin
          if (w_scored) begin
            // Pulses fire even when the matching counter is already saturated.
            if (w_press_hit) begin
              r_hit <= 1'b1;
              if (r_hits != '1) r_hits <= r_hits + 1'b1;
            end else begin
              r_miss <= 1'b1;
              if (r_misses != '1) r_misses <= r_misses + 1'b1;
            end
            r_round <= r_round + 1'b1;
            r_state <= w_last_round ? DONE : GAP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign led       = (r_state == SHOW) ? w_tgt_oh :
                     (r_state == DONE) ? LED_ALL_ON : 4'b0000;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign hits      = r_hits;
  assign misses    = r_misses;
  assign busy      = (r_state == GAP) || (r_state == SHOW);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_target_round_ctrl.sv
// Directed bench for target_round_ctrl with a pulse-driven score scoreboard.
module tb_target_round_ctrl;
  import game_pkg::*;

  localparam int GAP  = 4;
  localparam int ON   = 6;
  localparam int NR   = 5;
  localparam int SW   = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    random_num = 2'd0;
  logic [3:0]    btn = 4'd0;
  logic [3:0]    led;
  logic          hit;
  logic          miss;
  logic [SW-1:0] hits;
  logic [SW-1:0] misses;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  target_round_ctrl #(
    .GAP_CYCLES (GAP),
    .ON_CYCLES  (ON),
    .NUM_ROUNDS (NR),
    .SCORE_W    (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .random_num (random_num),
    .btn        (btn),
    .led        (led),
    .hit        (hit),
    .miss       (miss),
    .hits       (hits),
    .misses     (misses),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;
  int exp_hits   = 0;
  int exp_misses = 0;
  int exp_round  = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected entry is {hit, miss, hits, misses} as seen in the pulse cycle.
  task automatic push_expect(input bit is_hit);
    logic [SW-1:0] eh;
    logic [SW-1:0] em;
    if (is_hit) exp_hits   = (exp_hits   < SMAX) ? exp_hits + 1   : SMAX;
    else        exp_misses = (exp_misses < SMAX) ? exp_misses + 1 : SMAX;
    eh = SW'(exp_hits);
    em = SW'(exp_misses);
    exp_q.push_back({is_hit, !is_hit, eh, em});
  endtask

  always @(negedge clk) begin
    if (hit || miss) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got hit=%0b miss=%0b, expected no pulse", hit, miss);
      end else begin
        mon_e = exp_q.pop_front();
        check("score_pulse", int'({hit, miss, hits, misses}), int'(mon_e));
      end
    end
  end

  task automatic start_game(input logic [1:0] tgt);
    random_num = tgt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    exp_round  = 0;
    check("start_busy", int'(busy), 1);
    check("start_hits_clr", int'(hits), 0);
    check("start_misses_clr", int'(misses), 0);
    check("start_done_low", int'(done), 0);
  endtask

  // Entered on the first GAP cycle; idx < 0 means let the target time out.
  task automatic play_round(input logic [1:0] tgt, input logic [3:0] press,
                            input int idx, input bit noise);
    int cnt;
    logic [3:0] oh;
    oh = 4'b0001 << tgt;
    random_num = tgt;
    cnt = 0;
    if (noise) begin
      btn = 4'b1111;
      @(negedge clk);
      btn = 4'b0000;
      cnt = 1;
    end
    while (led == 4'b0000 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("gap_len", cnt, GAP);
    check("led_lit", int'(led), int'(oh));
    random_num = ~tgt;
    if (idx < 0) begin
      push_expect(1'b0);
      cnt = 0;
      while (led == oh && cnt < 20) begin
        cnt++;
        @(negedge clk);
      end
      check("lit_len", cnt, ON);
    end else begin
      for (int i = 0; i < idx; i++) @(negedge clk);
      check("led_before_press", int'(led), int'(oh));
      push_expect(press == oh);
      btn = press;
      @(negedge clk);
      btn = 4'b0000;
    end
    exp_round++;
    if (exp_round == NR) begin
      check("end_led_all", int'(led), 15);
      check("end_done", int'(done), 1);
      check("end_busy", int'(busy), 0);
    end else begin
      check("next_led_dark", int'(led), 0);
      check("next_busy", int'(busy), 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected finish earlier");
    $fatal(1);
  end

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    check("rst_led", int'(led), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_miss", int'(miss), 0);
    check("rst_hits", int'(hits), 0);
    check("rst_misses", int'(misses), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    rst = 1'b1;
    @(negedge clk);
    check("idle_hold", int'(dbg_state), int'(IDLE));

    // Game 1: hit, wrong press, multi-press miss, timeout, hit on timeout cycle.
    start_game(2'd2);
    play_round(2'd2, 4'b0100, 1, 1'b0);
    play_round(2'd1, 4'b1000, 0, 1'b0);
    play_round(2'd1, 4'b0011, 3, 1'b0);
    play_round(2'd3, 4'b0000, -1, 1'b0);
    play_round(2'd0, 4'b0001, ON - 1, 1'b0);
    repeat (3) @(negedge clk);
    check("g1_hits", int'(hits), 2);
    check("g1_misses", int'(misses), 3);
    check("g1_done_hold", int'(done), 1);
    check("g1_led_hold", int'(led), 15);

    // Game 2: five misses saturate the miss counter; gap presses are ignored.
    start_game(2'd0);
    play_round(2'd0, 4'b0010, 0, 1'b0);
    play_round(2'd3, 4'b0000, -1, 1'b1);
    play_round(2'd2, 4'b1111, 2, 1'b0);
    play_round(2'd1, 4'b0000, -1, 1'b0);
    play_round(2'd0, 4'b1000, 4, 1'b1);
    @(negedge clk);
    check("g2_hits", int'(hits), 0);
    check("g2_misses_sat", int'(misses), 3);

    // Game 3: start ignored in SHOW, then reset mid-SHOW.
    start_game(2'd2);
    play_round(2'd2, 4'b0100, 0, 1'b0);
    random_num = 2'd1;
    cnt = 0;
    while (led == 4'b0000 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("g3_gap_len", cnt, GAP);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("show_start_led", int'(led), 2);
    check("show_start_busy", int'(busy), 1);
    check("show_start_hits", int'(hits), 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_led", int'(led), 0);
    check("midrst_hits", int'(hits), 0);
    check("midrst_misses", int'(misses), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_state", int'(dbg_state), int'(IDLE));
    rst = 1'b1;
    btn = 4'b0100;
    @(negedge clk);
    btn = 4'b0000;
    repeat (3) @(negedge clk);
    check("idle_btn_state", int'(dbg_state), int'(IDLE));
    check("idle_btn_led", int'(led), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
